red_pitaya_iir_cascade: RTL and testbench

- Cascade of STAGES first-order low-/high-pass sections with per-stage configuration.
- Evaluated by one shared arithmetic datapath, time-multiplexed under a sequencer, so stage count scales without extra adders.
- Sample-strobed valid/ready interface, extended shift range, saturation with a sticky flag, bumpless bypass and synchronous state clear.
- Sits between ADC/demodulator paths and PID/scope inputs.

---
 rtl/red_pitaya_iir_pkg.sv | 29 ++
 rtl/red_pitaya_iir_section.sv | 53 +++++
 rtl/red_pitaya_iir_cascade.sv | 110 +++++++++++
 tb/tb_red_pitaya_iir_cascade.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/red_pitaya_iir_pkg.sv
// Shared definitions for the time-multiplexed IIR cascade: FSM encoding,
// per-stage config byte layout and the signed clamp helper.
package red_pitaya_iir_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int ON_BIT    = 7;
  localparam int HP_BIT    = 6;
  localparam int SHIFT_LSB = 0;

  // Clamp v to a w-bit signed range; callers take the low w bits of the result.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int w,
                                                  output logic clamped);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    clamped  = 1'b0;
    saturate = v;
    if (v > hi) begin
      saturate = hi;
      clamped  = 1'b1;
    end else if (v < lo) begin
      saturate = lo;
      clamped  = 1'b1;
    end
  endfunction

endpackage

// File: rtl/red_pitaya_iir_section.sv
// Combinational first-order section: updates one accumulator and produces
// the low- or high-pass output of that stage.
module red_pitaya_iir_section
  import red_pitaya_iir_pkg::*;
#(
  parameter int DW        = 16,
  parameter int SHIFTBITS = 4,
  parameter int MINSHIFT  = 10,
  parameter int MAXSHIFT  = MINSHIFT + (1 << SHIFTBITS) - 1,
  parameter int ACCW      = DW + MAXSHIFT + 1
) (
  input  logic signed [DW-1:0]   x,
  input  logic signed [ACCW-1:0] acc,
  input  logic [SHIFTBITS-1:0]   shift,
  input  logic                   on,
  input  logic                   highpass,
  output logic signed [ACCW-1:0] acc_next,
  output logic signed [DW-1:0]   y,
  output logic                   sat
);

  logic signed [ACCW:0] target, delta, sum, lp_full;
  logic signed [63:0]   lp_w, hp_w;
  logic signed [DW-1:0] lp;
  logic                 lp_c, hp_c;
  logic [7:0]           k;
  logic                 unused_hi;

  always_comb begin
    k       = 8'(shift) + 8'(MINSHIFT);
    target  = (ACCW+1)'(x) <<< MAXSHIFT;
    // One guard bit above ACCW keeps the difference exact before the shift.
    delta   = (target - (ACCW+1)'(acc)) >>> k;
    sum     = (ACCW+1)'(acc) + delta;
    lp_full = sum >>> MAXSHIFT;
    lp_c    = 1'b0;
    hp_c    = 1'b0;
    lp_w    = saturate(64'(lp_full), DW, lp_c);
    lp      = lp_w[DW-1:0];
    hp_w    = saturate(64'(x) - 64'(lp), DW, hp_c);
    acc_next = target[ACCW-1:0];
    y        = x;
    sat      = 1'b0;
    if (on) begin
      acc_next = sum[ACCW-1:0];
      y        = highpass ? hp_w[DW-1:0] : lp;
      sat      = lp_c | (highpass & hp_c);
    end
  end

  assign unused_hi = ^{lp_w[63:DW], hp_w[63:DW]};

endmodule

// File: rtl/red_pitaya_iir_cascade.sv
// STAGES cascaded first-order sections evaluated one per cycle on a single
// shared section datapath; accepts one sample per STAGES+2 cycles.
module red_pitaya_iir_cascade
  import red_pitaya_iir_pkg::*;
#(
  parameter int STAGES          = 4,
  parameter int SIGNALBITS      = 14,
  parameter int EXTRAOUTPUTBITS = 2,
  parameter int SHIFTBITS       = 4,
  parameter int MINSHIFT        = 10,
  localparam int DW       = SIGNALBITS + EXTRAOUTPUTBITS,
  localparam int MAXSHIFT = MINSHIFT + (1 << SHIFTBITS) - 1,
  localparam int ACCW     = DW + MAXSHIFT + 1,
  localparam int SW       = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [8*STAGES-1:0]          set_filter,
  input  logic                         clear_i,
  input  logic signed [SIGNALBITS-1:0] dat_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic signed [DW-1:0]         dat_o,
  output logic                         valid_o,
  output logic                         sat_o
);

  localparam logic [SW-1:0] LAST = SW'(STAGES - 1);

  state_t                        state, state_nx;
  logic [SW-1:0]                 s;
  logic [STAGES-1:0][ACCW-1:0]   acc;
  logic [STAGES-1:0][7:0]        cfg;
  logic [7:0]                    cfg_cur;
  logic signed [DW-1:0]          x_reg, y;
  logic signed [ACCW-1:0]        acc_nx;
  logic                          sec_sat;
  logic                          unused_cfg;

  assign cfg_cur    = cfg[s];
  assign unused_cfg = ^cfg_cur;

  red_pitaya_iir_section #(
    .DW(DW), .SHIFTBITS(SHIFTBITS), .MINSHIFT(MINSHIFT)
  ) u_section (
    .x        (x_reg),
    .acc      (acc[s]),
    .shift    (cfg_cur[SHIFT_LSB +: SHIFTBITS]),
    .on       (cfg_cur[ON_BIT]),
    .highpass (cfg_cur[HP_BIT]),
    .acc_next (acc_nx),
    .y        (y),
    .sat      (sec_sat)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (valid_i) state_nx = RUN;
      RUN:     if (s == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (clear_i) state_nx = IDLE;
  end

  assign ready_o = (state == IDLE) && !rst_i;
  assign valid_o = (state == DONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s     <= '0;
      acc   <= '0;
      cfg   <= '0;
      x_reg <= '0;
      dat_o <= '0;
      sat_o <= 1'b0;
    end else if (clear_i) begin
      s     <= '0;
      acc   <= '0;
      sat_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (valid_i) begin
          x_reg <= DW'(dat_i);
          cfg   <= set_filter;
          s     <= '0;
        end
        RUN: begin
          acc[s] <= acc_nx;
          x_reg  <= y;
          if (sec_sat) sat_o <= 1'b1;
          if (s == LAST) begin
            dat_o <= y;
            s     <= '0;
          end else begin
            s <= s + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_red_pitaya_iir_cascade.sv
// Scoreboard bench: the driver pushes model predictions on each accept, a
// negedge monitor pops and compares whenever valid_o is seen.
module tb_red_pitaya_iir_cascade;

  localparam int STAGES    = 2;
  localparam int SIGBITS   = 14;
  localparam int DW        = 14;
  localparam int SHIFTBITS = 4;
  localparam int MINSHIFT  = 0;
  localparam int MAXSHIFT  = MINSHIFT + (1 << SHIFTBITS) - 1;
  localparam longint SCALE = longint'(1) << MAXSHIFT;
  localparam longint DMAX  = (longint'(1) << (DW - 1)) - 1;
  localparam longint DMIN  = -(longint'(1) << (DW - 1));

  logic                      clk, rst_i, clear_i, valid_i, ready_o, valid_o, sat_o;
  logic [8*STAGES-1:0]       set_filter;
  logic signed [SIGBITS-1:0] dat_i;
  logic signed [DW-1:0]      dat_o;

  red_pitaya_iir_cascade #(
    .STAGES(STAGES), .SIGNALBITS(SIGBITS), .EXTRAOUTPUTBITS(0),
    .SHIFTBITS(SHIFTBITS), .MINSHIFT(MINSHIFT)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .set_filter(set_filter), .clear_i(clear_i),
    .dat_i(dat_i), .valid_i(valid_i), .ready_o(ready_o), .dat_o(dat_o),
    .valid_o(valid_o), .sat_o(sat_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  longint macc[STAGES];
  bit     msat;
  longint mlast;

  function automatic longint fdiv(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint clampv(input longint v);
    if (v > DMAX) begin msat = 1; return DMAX; end
    if (v < DMIN) begin msat = 1; return DMIN; end
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < STAGES; i++) macc[i] = 0;
    msat = 0;
  endtask

  task automatic model_sample(input longint d, input logic [8*STAGES-1:0] c,
                              output longint yout);
    longint x, lp, k;
    x = d;
    for (int st = 0; st < STAGES; st++) begin
      k = longint'(c[8*st +: SHIFTBITS]) + MINSHIFT;
      if (!c[8*st+7]) begin
        macc[st] = x * SCALE;
      end else begin
        macc[st] = macc[st] + fdiv(x * SCALE - macc[st], longint'(1) << k);
        lp = clampv(fdiv(macc[st], SCALE));
        x  = c[8*st+6] ? clampv(x - lp) : lp;
      end
    end
    yout  = x;
    mlast = x;
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    longint dat;
    bit     sat;
    int     cyc;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (!rst_i && valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got dat_o=%0d with no sample outstanding", dat_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("dat_o", longint'(dat_o), mon_e.dat);
        check("sat_o", longint'(sat_o), longint'(mon_e.sat));
        check("latency", longint'(cyc), longint'(mon_e.cyc + STAGES));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic wait_ready();
    int n = 0;
    while (!ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) check("ready_timeout", longint'(ready_o), 1);
  endtask

  task automatic send(input longint d, input logic [8*STAGES-1:0] c,
                      input logic [8*STAGES-1:0] c_mid);
    longint y;
    exp_t   e;
    int     n;
    wait_ready();
    dat_i = d[SIGBITS-1:0];
    set_filter = c;
    valid_i = 1;
    @(posedge clk);
    model_sample(d, c, y);
    @(negedge clk);
    valid_i = 0;
    set_filter = c_mid;
    e.dat = y;
    e.sat = msat;
    e.cyc = cyc;
    exp_q.push_back(e);
    n = 0;
    while (!ready_o && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("ready_low_cycles", longint'(n), longint'(STAGES + 1));
  endtask

  task automatic do_clear();
    clear_i = 1;
    @(negedge clk);
    clear_i = 0;
    model_clear();
    check("clear_sat", longint'(sat_o), 0);
  endtask

  task automatic send_abort(input longint d, input logic [8*STAGES-1:0] c,
                            input bit use_reset);
    wait_ready();
    dat_i = d[SIGBITS-1:0];
    set_filter = c;
    valid_i = 1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 0;
    if (!use_reset) begin
      clear_i = 1;
      @(negedge clk);
      clear_i = 0;
      model_clear();
      check("abort_clear_ready", longint'(ready_o), 1);
      check("abort_clear_dat_hold", longint'(dat_o), mlast);
      check("abort_clear_sat", longint'(sat_o), 0);
    end else begin
      rst_i = 1;
      #1;
      check("abort_rst_ready", longint'(ready_o), 0);
      check("abort_rst_dat", longint'(dat_o), 0);
      check("abort_rst_valid", longint'(valid_o), 0);
      @(negedge clk);
      rst_i = 0;
      model_clear();
      mlast = 0;
      #1;
      check("abort_rst_ready_back", longint'(ready_o), 1);
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [8*STAGES-1:0] c, cm;
    longint d;
    clk = 0; rst_i = 1; clear_i = 0; valid_i = 0; dat_i = '0; set_filter = '0;
    model_clear();
    mlast = 0;
    repeat (3) @(negedge clk);
    check("rst_dat_o", longint'(dat_o), 0);
    check("rst_valid_o", longint'(valid_o), 0);
    check("rst_sat_o", longint'(sat_o), 0);
    check("rst_ready_o", longint'(ready_o), 0);
    rst_i = 0;
    #1;
    check("ready_after_rst", longint'(ready_o), 1);
    @(negedge clk);

    // stage0 lowpass shift 1, stage1 off
    repeat (3) send(1000, 16'h0081, 16'h0081);
    // stage0 highpass shift 1
    do_clear();
    repeat (3) send(1000, 16'h00C1, 16'h00C1);
    // both stages off: pass-through
    do_clear();
    send(-4321, 16'h0000, 16'h0000);
    send(8191, 16'h0000, 16'h0000);
    send(-8192, 16'h0000, 16'h0000);

    // saturation: settle stage0 at -8192 then step it as a slow highpass
    do_clear();
    send(-8192, 16'h0000, 16'h0000);
    send(8191, 16'h00CF, 16'h00CF);
    send(0, 16'h00CF, 16'h00CF);
    do_clear();
    send(1000, 16'h0081, 16'h0081);

    // abort by clear and by reset right after accept
    send_abort(1234, 16'h0081, 0);
    send(1000, 16'h0081, 16'h0081);
    send_abort(-777, 16'h0081, 1);
    send(1000, 16'h0081, 16'h0081);

    // clear together with valid drops the sample
    wait_ready();
    dat_i = 14'sd777;
    valid_i = 1;
    clear_i = 1;
    @(negedge clk);
    valid_i = 0;
    clear_i = 0;
    model_clear();
    check("clear_with_valid_ready", longint'(ready_o), 1);

    // config change mid-sample only affects the next sample
    do_clear();
    send(1000, 16'h0081, 16'h00C1);
    send(1000, 16'h00C1, 16'h00C1);

    // randomized configs and samples
    for (int i = 0; i < 80; i++) begin
      c  = 16'($urandom);
      cm = ($urandom_range(0, 3) == 0) ? 16'($urandom) : c;
      d  = longint'($urandom_range(0, 16383)) - 8192;
      if ($urandom_range(0, 9) == 0) do_clear();
      send(d, c, cm);
    end

    repeat (10) @(negedge clk);
    check("queue_empty", longint'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
